demux_1to32_seq: RTL and testbench
==================================

# demux_1to32_seq

Registered 1-to-32 demultiplexer: the return path for the 32:1 mux. It steers a single serial data bit into one of 32 output slots, addressed either by an external select or by an internal auto-incrementing pointer. It tracks which slots have been written since the last clear and signals when the whole 32-bit word is assembled. Its registered output word can be looped straight back into the 32:1 mux for round-trip checking.

## Interface
Parameters:
- N, 32, number of output slots; must equal 2**SEL_W
- SEL_W, 5, select/pointer width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- inp  input  1  serial data bit to be steered
- sel  input  SEL_W  external slot address (used when auto=0)
- wr_en  input  1  write strobe; one slot written per cycle when high
- auto  input  1  1 = address from internal pointer, 0 = address from sel
- clr  input  1  synchronous clear of OUT, valid_map, ptr and state
- OUT  output  N  registered demultiplexed word
- valid_map  output  N  bit i = slot i written since last clear/reset
- ptr  output  SEL_W  internal pointer (next auto address)
- full  output  1  high while valid_map is all ones (state FULL)
- done  output  1  one-cycle pulse on entry to FULL

## Operation
- Effective address: addr = auto ? ptr : sel.
- Write: on wr_en, OUT[addr] <= inp and valid_map[addr] <= 1. All other slots hold.
- ptr increments only on a write with auto=1. It wraps from N-1 to 0 and is unchanged by writes with auto=0.
- FSM states and transitions:
  - IDLE: after reset/clr, valid_map=0. Any write -> FILL.
  - FILL: accumulate writes. When the write completes valid_map (next value all ones) -> FULL, and done pulses in the same cycle full rises. A single-slot N is not supported.
  - FULL: further writes still update OUT. valid_map stays all ones, done does not re-pulse, and ptr keeps wrapping. Leaves FULL only on clr/rst -> IDLE.
- Rewrites of an already-valid slot overwrite OUT with the newest value.
- clr and wr_en in the same cycle: clr wins and the write is discarded.
- rst and clr have identical effect; rst also clears the collision flag when it is configured.

## Timing
- Reset values: OUT=0, valid_map=0, ptr=0, full=0, done=0, state=IDLE.
- Write latency: OUT, valid_map and ptr reflect a write one clock after the edge that samples wr_en.
- full and done are registered and assert on the same edge that sets the last valid_map bit.
- done is high for exactly one cycle.
- Back-to-back writes are supported every cycle. There is no backpressure, and the block is always ready.
- Reset or clr mid-fill aborts the fill. The next cycle is in IDLE with all outputs at reset values.
- auto may change every cycle. The address is taken from the current cycle's auto/sel/ptr.

## Configuration
- Macro: DEMUX_COLLISION_EN.
- Defined:
  - Adds output collision (1 bit, reset 0).
  - collision is sticky. It sets one cycle after a write in FILL targets a slot whose valid_map bit is already 1.
  - It is cleared only by rst or clr.
  - Writes in FULL never set it.
- Undefined: no collision port and no associated logic. All other behaviour is identical.

## Test plan
- Reset: hold rst 2 cycles with wr_en=1, inp=1 -> OUT=0, valid_map=0, ptr=0, full=0, done=0 throughout and one cycle after release.
- Auto sweep:
  - Stimulus: auto=1, wr_en=1 for 32 cycles, inp = bit i of 32'hABCD_EF12 on cycle i.
  - Response: OUT=32'hABCD_EF12; full rises with a single done pulse on the 32nd write; ptr=0.
  - Then feed OUT back through the 32:1 mux with sel 0..31 and check each bit.
- Addressed writes:
  - Stimulus: auto=0, write inp=1 to sel=31, then sel=0, then sel=15.
  - Response: OUT=32'h8000_8001, valid_map=32'h8000_8001, ptr=0, full=0.
- Clr priority: in FILL, assert clr and wr_en together with sel=3, inp=1 -> next cycle OUT=0, valid_map=0, state IDLE.
- FULL overwrite: after the auto sweep, write inp=0 to sel=1 -> OUT=32'hABCD_EF10, full stays 1, no second done.
- Collision (DEMUX_COLLISION_EN): write sel=5 twice in FILL -> collision=1 one cycle after the second write; it stays 1 until clr.

Source files
------------

// File: rtl/demux_1to32_seq.sv
// demux_1to32_seq: registered 1-to-N demultiplexer with slot-valid tracking.
// A serial bit is steered into one of N output slots, addressed either by an
// external select or by an internal wrapping pointer. The block reports when
// every slot has been written since the last clear (full) and pulses done once
// on that transition.
// Optional feature macro: DEMUX_COLLISION_EN adds a sticky collision flag that
// marks a rewrite of an already-valid slot while the word is still filling.

// One output slot: data bit plus its written-since-clear flag.
module demux_1to32_slot (
    input  logic clk,
    input  logic i_clear,
    input  logic i_we,
    input  logic i_d,
    output logic o_q,
    output logic o_v
);

    logic r_q;
    logic r_v;

    // Clear dominates; a write captures the newest bit and marks the slot valid.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_q <= 1'b0;
            r_v <= 1'b0;
        end else if (i_we) begin
            r_q <= i_d;
            r_v <= 1'b1;
        end
    end

    assign o_q = r_q;
    assign o_v = r_v;

endmodule

module demux_1to32_seq #(
    parameter int N     = 32,   // must equal 2**SEL_W so the pointer wraps naturally
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inp,
    input  logic [SEL_W-1:0] sel,
    input  logic             wr_en,
    input  logic             auto,
    input  logic             clr,
    output logic [N-1:0]     OUT,
    output logic [N-1:0]     valid_map,
    output logic [SEL_W-1:0] ptr,
    output logic             full,
    output logic             done
`ifdef DEMUX_COLLISION_EN
    ,
    output logic             collision
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic [SEL_W-1:0]   r_ptr;

    logic               w_clear;
    logic               w_wr;
    logic [SEL_W-1:0]   w_addr;
    logic [N-1:0]       w_dec;
    logic [N-1:0]       w_slot_we;
    logic [N-1:0]       w_out;
    logic [N-1:0]       w_valid;
    logic [N-1:0]       w_valid_nxt;
    logic               w_complete;

    // rst and clr are interchangeable; either one discards a same-cycle write.
    assign w_clear     = rst | clr;
    assign w_wr        = wr_en & ~w_clear;
    assign w_addr      = auto ? r_ptr : sel;
    assign w_dec       = {{(N-1){1'b0}}, 1'b1} << w_addr;
    assign w_slot_we   = w_wr ? w_dec : '0;
    assign w_valid_nxt = w_valid | w_slot_we;
    assign w_complete  = w_wr & (&w_valid_nxt);

    // One slot cell per output bit.
    for (genvar g = 0; g < N; g++) begin : g_slot
        demux_1to32_slot u_slot (
            .clk     (clk),
            .i_clear (w_clear),
            .i_we    (w_slot_we[g]),
            .i_d     (inp),
            .o_q     (w_out[g]),
            .o_v     (w_valid[g])
        );
    end

    // Pointer advances only on auto-addressed writes; wraps at N-1 -> 0.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_ptr <= '0;
        end else if (w_wr && auto) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    // State and done-pulse registers.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next state: the write that completes the map moves to FULL and arms done.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_wr) begin
                    w_state_nxt = w_complete ? FULL : FILL;
                    w_done_nxt  = w_complete;
                end
            end
            FILL: begin
                if (w_complete) begin
                    w_state_nxt = FULL;
                    w_done_nxt  = 1'b1;
                end
            end
            FULL: begin
                w_state_nxt = FULL;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef DEMUX_COLLISION_EN
    logic r_collision;

    // Sticky flag: a FILL-state write to a slot that is already valid.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_collision <= 1'b0;
        end else if (r_state == FILL && w_wr && |(w_dec & w_valid)) begin
            r_collision <= 1'b1;
        end
    end

    assign collision = r_collision;
`endif

    assign OUT       = w_out;
    assign valid_map = w_valid;
    assign ptr       = r_ptr;
    assign full      = (r_state == FULL);
    assign done      = r_done;

endmodule

// File: tb/tb_demux_1to32_seq.sv
// Directed bench for demux_1to32_seq: reset, auto sweep with mux loopback,
// FULL overwrite, addressed writes, clr priority, mixed addressing, collision.
module tb_demux_1to32_seq;

    logic        clk = 1'b0;
    logic        rst, inp, wr_en, auto, clr;
    logic [4:0]  sel;
    logic [31:0] OUT, valid_map;
    logic [4:0]  ptr;
    logic        full, done;
`ifdef DEMUX_COLLISION_EN
    logic        collision;
`endif

    int checks = 0;
    int errors = 0;

    demux_1to32_seq dut (
        .clk       (clk),
        .rst       (rst),
        .inp       (inp),
        .sel       (sel),
        .wr_en     (wr_en),
        .auto      (auto),
        .clr       (clr),
        .OUT       (OUT),
        .valid_map (valid_map),
        .ptr       (ptr),
        .full      (full),
        .done      (done)
`ifdef DEMUX_COLLISION_EN
        ,
        .collision (collision)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] o, input logic [31:0] v,
                           input logic [4:0] p, input logic f, input logic d);
        chk({tag, ".OUT"},  OUT,       o);
        chk({tag, ".vmap"}, valid_map, v);
        chk({tag, ".ptr"},  {27'd0, ptr},  {27'd0, p});
        chk({tag, ".full"}, {31'd0, full}, {31'd0, f});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
    endtask

    initial begin
        logic [31:0] pat;
        logic        muxbit;
        pat = 32'hABCD_EF12;

        // Reset held two cycles with a write pending; nothing may be written.
        rst = 1; clr = 0; wr_en = 1; inp = 1; auto = 1; sel = 5'd7;
        tick(); chk_all("rst_c1", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        tick(); chk_all("rst_c2", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        rst = 0; wr_en = 0;
        tick(); chk_all("rst_rel", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);

        // Auto sweep: 32 writes of pattern bits, done on the 32nd only.
        auto = 1; wr_en = 1;
        for (int i = 0; i < 32; i++) begin
            inp = pat[i];
            tick();
            chk($sformatf("sweep_done%0d", i), {31'd0, done}, {31'd0, (i == 31)});
            chk($sformatf("sweep_full%0d", i), {31'd0, full}, {31'd0, (i == 31)});
            chk($sformatf("sweep_ptr%0d", i),  {27'd0, ptr},  32'((i + 1) % 32));
        end
        chk_all("sweep_end", 32'hABCD_EF12, 32'hFFFF_FFFF, 5'd0, 1'b1, 1'b1);
        wr_en = 0;
        tick(); chk_all("sweep_hold", 32'hABCD_EF12, 32'hFFFF_FFFF, 5'd0, 1'b1, 1'b0);

        // Loop OUT back through a 32:1 mux model and compare each selected bit.
        for (int s = 0; s < 32; s++) begin
            sel = 5'(s);
            #1;
            muxbit = OUT[sel];
            chk($sformatf("mux_sel%0d", s), {31'd0, muxbit}, {31'd0, pat[s]});
        end

        // FULL overwrite: slot 1 rewritten to 0, no second done.
        auto = 0; sel = 5'd1; inp = 0; wr_en = 1;
        tick(); chk_all("full_ovw", 32'hABCD_EF10, 32'hFFFF_FFFF, 5'd0, 1'b1, 1'b0);
        wr_en = 0;
        tick(); chk_all("full_ovw2", 32'hABCD_EF10, 32'hFFFF_FFFF, 5'd0, 1'b1, 1'b0);

        // clr from FULL returns everything to reset values.
        clr = 1;
        tick(); chk_all("clr_full", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        clr = 0;

        // Addressed writes to 31, 0, 15.
        auto = 0; wr_en = 1; inp = 1;
        sel = 5'd31; tick();
        sel = 5'd0;  tick();
        sel = 5'd15; tick();
        chk_all("addr_wr", 32'h8000_8001, 32'h8000_8001, 5'd0, 1'b0, 1'b0);

        // clr together with a write: clr wins.
        clr = 1; sel = 5'd3; inp = 1; wr_en = 1;
        tick(); chk_all("clr_prio", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        clr = 0;

        // Back in IDLE: addressed write then auto write (pointer at 0).
        sel = 5'd3; inp = 1; wr_en = 1; auto = 0;
        tick(); chk_all("idle_wr", 32'h0000_0008, 32'h0000_0008, 5'd0, 1'b0, 1'b0);
        auto = 1; inp = 1;
        tick(); chk_all("mix_auto", 32'h0000_0009, 32'h0000_0009, 5'd1, 1'b0, 1'b0);
        auto = 0; sel = 5'd20; inp = 0;
        tick(); chk_all("mix_sel", 32'h0000_0009, 32'h0010_0009, 5'd1, 1'b0, 1'b0);

        // rst mid-fill aborts.
        rst = 1; wr_en = 1;
        tick(); chk_all("rst_mid", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        rst = 0; wr_en = 0;

`ifdef DEMUX_COLLISION_EN
        chk("coll_rst", {31'd0, collision}, 32'd0);
        auto = 0; sel = 5'd5; inp = 1; wr_en = 1;
        tick(); chk("coll_first", {31'd0, collision}, 32'd0);
        inp = 0;
        tick(); chk("coll_second", {31'd0, collision}, 32'd1);
        wr_en = 0;
        tick(); chk("coll_sticky", {31'd0, collision}, 32'd1);
        clr = 1;
        tick(); chk("coll_clr", {31'd0, collision}, 32'd0);
        clr = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
